apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB slave sitting directly downstream of the team's APB master; one instance hangs off each master select line (Psel_1, Psel_2).
- Implements a byte-strobed, word-addressed register memory with a parameterised number of wait states (Pready throttling) and an error response (Pslverr) for out-of-range addresses.
- Consumes the master's Paddr, which already has the slave-select MSB stripped.

Parameters:
- ADD_WIDTH, 8, Paddr width (word address; equals master ADD_WIDTH-1).
- WIDTH, 32, data width; must be a multiple of 8.
- DEPTH, 64, implemented words; legal addresses are 0..DEPTH-1; DEPTH <= 2**ADD_WIDTH.
- WAIT_STATES, 0, Pready-low cycles inserted in the access phase (0..15).

Ports:
- pclk  in  1  clock, rising edge.
- presetn  in  1  asynchronous active-low reset.
- Psel  in  1  slave select from master.
- Penable  in  1  access-phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Pstrb  in  WIDTH/8  byte-lane write strobes.
- Paddr  in  ADD_WIDTH  word address.
- Pwdata  in  WIDTH  write data.
- Pready  out  1  transfer-complete, registered.
- Prdata  out  WIDTH  read data, registered.
- Pslverr  out  1  error, valid only while Pready=1.

Behaviour:
- Reset (async, presetn=0): state=IDLE, Pready=0, Pslverr=0, Prdata=0, wait counter=0, all DEPTH words cleared to 0. Reset asserted mid-transfer aborts the transfer and no write commits.
- FSM states: IDLE, WAIT, READY. Pready = (state==READY).
- Setup phase is detected as Psel=1 and Penable=0.
- IDLE:
  - On setup phase, load cnt=WAIT_STATES.
  - Next state is READY if WAIT_STATES==0, else WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - cnt decrements each cycle; at cnt==1, go to READY.
  - If Psel drops (protocol abort), return to IDLE and commit nothing.
- READY:
  - Held exactly one cycle; Pready=1; always returns to IDLE.
  - A back-to-back setup phase from the master in the following cycle is accepted from IDLE with no bubble.
- Latency:
  - Access phase lasts WAIT_STATES+1 cycles.
  - Total transfer is setup + WAIT_STATES + 1 cycles.
  - Zero-wait transfer: setup at cycle 0, Pready=1 at cycle 1.
- Address error: err = (Paddr >= DEPTH). Pslverr and the Prdata value are registered on the transition into READY.
- Read, on transition into READY:
  - Prdata <= err ? 0 : mem[Paddr].
  - Prdata holds its value until the next read completes; writes do not change it.
- Write commit:
  - Occurs on the clock edge ending the READY cycle when Psel & Penable & Pwrite.
  - For each byte b with Pstrb[b]=1, mem[Paddr][8b+7:8b] <= Pwdata byte b.
  - Lanes with strobe 0 are unchanged. Pstrb=0 is a legal no-op write.
  - An erroring write leaves memory unchanged.
- Reads ignore Pstrb.
- Pslverr=0 whenever Pready=0.
- Paddr, Pwrite, Pstrb and Pwdata are sampled as held stable by the master; the block does not capture them at setup.
- A read immediately after a write to the same address returns the new data, because the commit precedes the next setup.

Decomposition:
- Package apb_slave_pkg: state enum (IDLE=2'b00, WAIT=2'b01, READY=2'b10), wait-counter width constant (4), and byte-lane count function WIDTH/8.
- Sub-module apb_slave_regfile: DEPTH x WIDTH storage with async clear, byte-enable write port and combinational read port.
- The FSM, wait counter, error decode and output registers stay in apb_slave_mem.

Test Plan:
- Zero-wait write then read (WAIT_STATES=0): write Paddr=0x05, Pwdata=0xDEADBEEF, Pstrb=4'hF; read 0x05 -> Pready high in the 2nd cycle of each transfer, Prdata=0xDEADBEEF, Pslverr=0.
- Byte strobes: preload 0x11223344 at 0x0A, write 0xAABBCCDD with Pstrb=4'b0101 -> readback 0x11BB33DD; Pstrb=0 write -> data unchanged.
- Wait states (WAIT_STATES=3): single read -> Pready low for exactly 3 access cycles, high on the 4th; Psel dropped during WAIT -> FSM returns to IDLE, memory unchanged.
- Out of range (DEPTH=64): write 0x40 with 0xFFFFFFFF, then read 0x40 -> Pslverr=1 with Pready on both, Prdata=0; read 0x00 -> still 0.
- Back-to-back via master with transfer held high: three transfers alternating W/R -> no idle cycle between Pready pulses; async reset asserted mid-WAIT -> Pready=0, Prdata=0, all memory reads return 0 afterwards.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and constants for the APB slave memory
//
// Purpose: FSM state encoding, wait-counter width and byte-lane helper
//          used by apb_slave_mem and apb_slave_regfile.
// Ports:   none (package).

package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    READY = 2'b10
  } apb_state_e;

  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - DEPTH x WIDTH byte-enable register storage
//
// Purpose: word storage with asynchronous clear, one byte-strobed write
//          port and one combinational read port.
// Ports:
//   pclk, presetn   clock / async active-low clear of every word
//   we              write enable (caller guarantees waddr is in range)
//   waddr, wstrb    write word index and byte-lane strobes
//   wdata           write data
//   raddr, rdata    combinational read index and data

module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          we,
  input  logic [IDX_W-1:0]              waddr,
  input  logic [byte_lanes(WIDTH)-1:0]  wstrb,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [IDX_W-1:0]              raddr,
  output logic [WIDTH-1:0]              rdata
);

  localparam int NB = byte_lanes(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave with byte-strobed register memory
//
// Purpose: word-addressed memory behind an APB slave port with a fixed
//          number of wait states and an error response for addresses
//          at or beyond DEPTH.
// Ports:
//   pclk, presetn          clock / async active-low reset
//   Psel, Penable, Pwrite  APB control from the master
//   Pstrb, Paddr, Pwdata   byte strobes, word address, write data
//   Pready                 registered transfer-complete (one cycle)
//   Prdata                 registered read data, held between reads
//   Pslverr                registered error, only ever high with Pready

module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADD_WIDTH   = 8,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          Psel,
  input  logic                          Penable,
  input  logic                          Pwrite,
  input  logic [byte_lanes(WIDTH)-1:0]  Pstrb,
  input  logic [ADD_WIDTH-1:0]          Paddr,
  input  logic [WIDTH-1:0]              Pwdata,
  output logic                          Pready,
  output logic [WIDTH-1:0]              Prdata,
  output logic                          Pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADD_WIDTH is representable.
  localparam logic [ADD_WIDTH:0] DEPTH_L  = DEPTH[ADD_WIDTH:0];
  localparam logic [CNT_W-1:0]   WAIT_CNT = WAIT_STATES[CNT_W-1:0];

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pready_q;
  logic              pslverr_q;
  logic [WIDTH-1:0]  prdata_q;

  logic              setup;
  logic              err;
  logic              enter_ready;
  logic              commit;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  rd_word;

  assign setup = Psel && !Penable;
  assign err   = ({1'b0, Paddr} >= DEPTH_L);
  assign idx   = Paddr[IDX_W-1:0];

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_STATES == 0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!Psel) begin
          // Master abandoned the transfer; nothing is committed.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_ready = (state_d == READY) && (state_q != READY);

  // Writes land on the edge that ends the READY cycle, so a setup that
  // follows immediately already sees the new contents.
  assign commit = (state_q == READY) && Psel && Penable && Pwrite && !err;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= (state_d == READY);
      if (enter_ready) begin
        pslverr_q <= err;
        // Prdata only moves on reads; writes leave the last read value.
        if (!Pwrite) begin
          prdata_q <= err ? '0 : rd_word;
        end
      end else begin
        pslverr_q <= 1'b0;
      end
    end
  end

  apb_slave_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (commit),
    .waddr   (idx),
    .wstrb   (Pstrb),
    .wdata   (Pwdata),
    .raddr   (idx),
    .rdata   (rd_word)
  );

  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;
  assign Prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem (0 and 3 wait states)

module tb_apb_slave_mem;

  localparam int AW  = 8;
  localparam int W   = 32;
  localparam int D   = 64;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [3:0]  pstrb   [2];
  logic [7:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADD_WIDTH(AW), .WIDTH(W), .DEPTH(D), .WAIT_STATES(WS0)) dut0 (
    .pclk(pclk), .presetn(presetn), .Psel(psel[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Pstrb(pstrb[0]), .Paddr(paddr[0]), .Pwdata(pwdata[0]),
    .Pready(pready[0]), .Prdata(prdata[0]), .Pslverr(pslverr[0])
  );

  apb_slave_mem #(.ADD_WIDTH(AW), .WIDTH(W), .DEPTH(D), .WAIT_STATES(WS1)) dut1 (
    .pclk(pclk), .presetn(presetn), .Psel(psel[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Pstrb(pstrb[1]), .Paddr(paddr[1]), .Pwdata(pwdata[1]),
    .Pready(pready[1]), .Prdata(prdata[1]), .Pslverr(pslverr[1])
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mdl_mem  [2][D];
  logic [31:0] mdl_last [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          last_ready_cyc [2];

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      mdl_last[d] = '0;
      for (int i = 0; i < D; i++) mdl_mem[d][i] = '0;
    end
  endfunction

  // Reference behaviour: in-range writes merge strobed bytes, reads
  // return the word (or 0 on error), Prdata sticks across writes.
  function automatic exp_t model_xfer(input int d, input bit wr, input logic [7:0] a,
                                      input logic [31:0] wd, input logic [3:0] s);
    exp_t        e;
    int          ai;
    logic [31:0] word;
    ai       = int'(a);
    e.slverr = (ai >= D);
    if (wr) begin
      e.rdata = mdl_last[d];
      if (ai < D) begin
        word = mdl_mem[d][ai];
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = wd[8*b +: 8];
        mdl_mem[d][ai] = word;
      end
    end else begin
      e.rdata     = (ai >= D) ? 32'h0 : mdl_mem[d][ai];
      mdl_last[d] = e.rdata;
    end
    return e;
  endfunction

  // Monitor: every Pready pops one expectation for that slave.
  always @(negedge pclk) begin
    if (presetn) begin
      for (int d = 0; d < 2; d++) begin
        if (!pready[d]) begin
          check($sformatf("slverr_without_ready[%0d]", d), {31'b0, pslverr[d]}, 32'h0);
        end else begin
          exp_t e;
          bit   have;
          have = 1'b0;
          e    = '0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          check($sformatf("ready_expected[%0d]", d), {31'b0, have}, 32'h1);
          if (have) begin
            check($sformatf("prdata[%0d]", d), prdata[d], e.rdata);
            check($sformatf("pslverr[%0d]", d), {31'b0, pslverr[d]}, {31'b0, e.slverr});
          end
        end
      end
    end
  end

  // Called #1 after a rising edge. Leaves Psel high when b2b is set so
  // the next call issues its setup phase in the very next cycle.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input bit b2b, input bit chk_gap);
    exp_t e;
    int   lat;
    e = model_xfer(d, wr, a, wd, s);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = s;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    lat = 0;
    do begin
      @(negedge pclk);
      lat++;
    end while (!pready[d] && lat < 40);
    check($sformatf("access_cycles[%0d]", d), 32'(lat), 32'(ws_of(d) + 1));
    if (chk_gap) check($sformatf("b2b_ready_gap[%0d]", d), 32'(cyc - last_ready_cyc[d]), 32'(ws_of(d) + 2));
    last_ready_cyc[d] = cyc;
    @(posedge pclk); #1;
    penable[d] = 1'b0;
    if (!b2b) begin
      psel[d] = 1'b0;
      @(posedge pclk); #1;
    end
  endtask

  // Write that never completes: Psel drops (or reset hits) during WAIT.
  task automatic abort_write(input int d, input logic [7:0] a, input logic [31:0] wd, input bit use_reset);
    int highs;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = 4'hF;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    @(posedge pclk); #1;
    if (use_reset) begin
      presetn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_pready[%0d]", k), {31'b0, pready[k]}, 32'h0);
        check($sformatf("rst_prdata[%0d]", k), prdata[k], 32'h0);
        check($sformatf("rst_pslverr[%0d]", k), {31'b0, pslverr[k]}, 32'h0);
      end
      model_clear();
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    highs = 0;
    repeat (6) begin
      @(negedge pclk);
      if (pready[d]) highs++;
    end
    check($sformatf("abort_no_ready[%0d]", d), 32'(highs), 32'h0);
    if (use_reset) begin
      @(posedge pclk); #1;
      presetn = 1'b1;
    end
    @(posedge pclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_b2b;
    bit b2b;
    presetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      pstrb[d] = '0; paddr[d] = '0; pwdata[d] = '0;
      last_ready_cyc[d] = 0;
    end
    model_clear();
    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_pready[%0d]", d), {31'b0, pready[d]}, 32'h0);
      check($sformatf("reset_pslverr[%0d]", d), {31'b0, pslverr[d]}, 32'h0);
      check($sformatf("reset_prdata[%0d]", d), prdata[d], 32'h0);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write then read.
    xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 1'b0);
    check("zero_wait_readback", prdata[0], 32'hDEADBEEF);

    // Byte strobes, then an all-zero strobe no-op.
    xfer(0, 1'b1, 8'h0A, 32'h11223344, 4'hF, 1'b0, 1'b0);
    xfer(0, 1'b1, 8'h0A, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h0A, 32'h0, 4'hF, 1'b0, 1'b0);
    check("strobe_merge", prdata[0], 32'h11BB33DD);
    xfer(0, 1'b1, 8'h0A, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h0A, 32'h0, 4'h0, 1'b0, 1'b0);
    check("strobe_zero_noop", prdata[0], 32'h11BB33DD);

    // Wait states and an abort during WAIT.
    xfer(1, 1'b1, 8'h03, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 1'b0);
    abort_write(1, 8'h03, 32'h0BADC0DE, 1'b0);
    xfer(1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 1'b0);
    check("abort_mem_unchanged", prdata[1], 32'hCAFEF00D);

    // Out of range.
    xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, 1'b0, 1'b0);
    check("oor_prdata", prdata[0], 32'h0);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0);
    check("oor_addr0_untouched", prdata[0], 32'h0);

    // Back-to-back W/R/W with no idle cycle.
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 8'h10, $urandom, 4'hF, 1'b1, 1'b0);
      xfer(d, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1, 1'b1);
      xfer(d, 1'b1, 8'h11, $urandom, 4'hF, 1'b0, 1'b1);
    end

    // Randomized traffic, including out-of-range addresses.
    for (int d = 0; d < 2; d++) begin
      prev_b2b = 1'b0;
      for (int i = 0; i < 60; i++) begin
        b2b = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
        xfer(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 71)), $urandom,
             4'($urandom_range(0, 15)), b2b, prev_b2b);
        prev_b2b = b2b;
      end
    end

    // Reset in the middle of WAIT clears everything.
    xfer(1, 1'b1, 8'h20, 32'h12345678, 4'hF, 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    abort_write(1, 8'h21, 32'h87654321, 1'b1);
    for (int i = 0; i < D; i++) xfer(1, 1'b0, 8'(i), 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 8'(i * 9), 32'h0, 4'h0, 1'b0, 1'b0);

    repeat (3) @(posedge pclk);
    check("scoreboard0_drained", 32'(q0.size()), 32'h0);
    check("scoreboard1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
